// File: rtl/score_uart_reporter.sv
// Score reporter: transmits "S:NN\n" as 8N1 UART frames (LSB first) whenever
// the score changes or a resend is requested.
module score_uart_reporter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_LEN    = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [5:0] score_in,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BYTE = 3'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] baud_cnt, baud_nx;
    logic [2:0]  bit_cnt, bit_nx;
    logic [2:0]  byte_idx, byte_nx;
    logic [5:0]  snapshot, snapshot_nx;
    logic [5:0]  last_reported, last_nx;
    logic        pending, pending_nx;
    logic        tx_nx, busy_nx, done_nx;
    logic [5:0]  tens, ones;
    logic [7:0]  cur_byte;
    logic        baud_wrap, trigger;

    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign trigger   = (score_in != last_reported) | send_req | pending;

    always_comb begin
        tens = snapshot / 6'd10;
        ones = snapshot % 6'd10;
        case (byte_idx)
            3'd0:    cur_byte = 8'h53;
            3'd1:    cur_byte = 8'h3A;
            3'd2:    cur_byte = 8'h30 + {2'b00, tens};
            3'd3:    cur_byte = 8'h30 + {2'b00, ones};
            default: cur_byte = 8'h0A;
        endcase
    end

    // tx/busy/frame_done are computed for the next state and registered
    always_comb begin
        state_nx    = state;
        baud_nx     = baud_cnt;
        bit_nx      = bit_cnt;
        byte_nx     = byte_idx;
        snapshot_nx = snapshot;
        last_nx     = last_reported;
        pending_nx  = pending | send_req;
        tx_nx       = 1'b1;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx    = START;
                    snapshot_nx = score_in;
                    last_nx     = score_in;
                    pending_nx  = 1'b0;
                    byte_nx     = 3'd0;
                    baud_nx     = 16'd0;
                    tx_nx       = 1'b0;
                    busy_nx     = 1'b1;
                end
            end
            START: begin
                busy_nx = 1'b1;
                if (baud_wrap) begin
                    state_nx = DATA;
                    baud_nx  = 16'd0;
                    bit_nx   = 3'd0;
                    tx_nx    = cur_byte[0];
                end else begin
                    baud_nx = baud_cnt + 16'd1;
                    tx_nx   = 1'b0;
                end
            end
            DATA: begin
                busy_nx = 1'b1;
                if (baud_wrap) begin
                    baud_nx = 16'd0;
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                        tx_nx  = cur_byte[bit_nx];
                    end
                end else begin
                    baud_nx = baud_cnt + 16'd1;
                    tx_nx   = cur_byte[bit_cnt];
                end
            end
            STOP: begin
                busy_nx = 1'b1;
                if (baud_wrap) begin
                    baud_nx = 16'd0;
                    if (byte_idx < LAST_BYTE) begin
                        byte_nx  = byte_idx + 3'd1;
                        state_nx = START;
                        tx_nx    = 1'b0;
                    end else begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end else begin
                    baud_nx = baud_cnt + 16'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            baud_cnt      <= 16'd0;
            bit_cnt       <= 3'd0;
            byte_idx      <= 3'd0;
            snapshot      <= 6'd0;
            last_reported <= 6'd0;
            pending       <= 1'b0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            baud_cnt      <= baud_nx;
            bit_cnt       <= bit_nx;
            byte_idx      <= byte_nx;
            snapshot      <= snapshot_nx;
            last_reported <= last_nx;
            pending       <= pending_nx;
            tx            <= tx_nx;
            busy          <= busy_nx;
            frame_done    <= done_nx;
        end
    end
endmodule

// File: tb/tb_score_uart_reporter.sv
// Bench for score_uart_reporter: UART frame decoder, event-level reference
// model, a vector table and directed multi-cycle sequences.
module tb_score_uart_reporter;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = 50 * CPB;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b0;
    logic [5:0] score_in   = 6'd0;
    logic       send_req   = 1'b0;
    logic       tx, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [39:0] rx_frames[$];
    int          rx_starts[$];
    logic [39:0] exp_frames[$];
    int          exp_starts[$];

    int         idle_at = 0;
    logic [5:0] m_last  = 6'd0;
    bit         m_pend  = 1'b0;

    score_uart_reporter #(.CLKS_PER_BIT(CPB), .FRAME_LEN(5)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .score_in   (score_in),
        .send_req   (send_req),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [39:0] fmt(input int v);
        logic [7:0] t, o;
        t = 8'(48 + v / 10);
        o = 8'(48 + v % 10);
        return {8'h53, 8'h3A, t, o, 8'h0A};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: a frame starts the edge after any idle-time trigger; the
    // transmitter is unavailable for 50*CPB+2 edges after each trigger.
    always @(posedge clk_100MHz) begin
        if (reset) begin
            exp_frames.delete();
            exp_starts.delete();
            m_last  = 6'd0;
            m_pend  = 1'b0;
            idle_at = 0;
        end else if (cyc >= idle_at && (score_in != m_last || send_req || m_pend)) begin
            exp_frames.push_back(fmt(int'(score_in)));
            exp_starts.push_back(cyc + 1);
            m_last  = score_in;
            m_pend  = 1'b0;
            idle_at = cyc + FRAME_CYC + 2;
        end else if (send_req) begin
            m_pend = 1'b1;
        end
        cyc++;
    end

    task automatic capture_frame();
        logic        samples[FRAME_CYC];
        logic [39:0] frame;
        logic [7:0]  b;
        int          start;
        bit          busy_ok, shape_ok;
        start   = cyc;
        busy_ok = 1'b1;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i > 0) @(negedge clk_100MHz);
            if (reset) return;
            samples[i] = tx;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        @(negedge clk_100MHz);
        if (reset) return;
        check("busy_during_frame", 64'(busy_ok), 64'd1);
        check("frame_done_pulse", {61'd0, frame_done, busy, tx}, 64'b101);
        shape_ok = 1'b1;
        frame    = 40'd0;
        for (int p = 0; p < 50; p++)
            for (int c = 1; c < CPB; c++)
                if (samples[p*CPB+c] !== samples[p*CPB]) shape_ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (samples[k*10*CPB] !== 1'b0 || samples[(k*10+9)*CPB] !== 1'b1) shape_ok = 1'b0;
            for (int j = 0; j < 8; j++) b[j] = samples[(k*10+1+j)*CPB];
            frame = {frame[31:0], b};
        end
        check("bit_framing", 64'(shape_ok), 64'd1);
        rx_frames.push_back(frame);
        rx_starts.push_back(start);
        if (exp_frames.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %h at cycle %0d, none expected", frame, start);
        end else begin
            check("frame_text", 64'(frame), 64'(exp_frames.pop_front()));
            check("frame_start_cycle", 64'(start), 64'(exp_starts.pop_front()));
        end
    endtask

    always begin : monitor
        @(negedge clk_100MHz);
        if (!reset) begin
            if (tx === 1'b0) capture_frame();
            else check("idle_outputs", {62'd0, busy, frame_done}, 64'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic wait_tx_low(input string name);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk_100MHz);
            n++;
        end
        check(name, 64'(tx), 64'd0);
    endtask

    typedef struct {
        logic [5:0]  score;
        logic        req;
        int          n_frames;
        logic [39:0] last_txt;
    } vec_t;

    vec_t vecs[9];
    int   n0;

    initial begin
        vecs[0] = '{6'd7,  1'b0, 1, "S:07\n"};
        vecs[1] = '{6'd7,  1'b0, 0, "S:07\n"};
        vecs[2] = '{6'd7,  1'b1, 1, "S:07\n"};
        vecs[3] = '{6'd63, 1'b1, 1, "S:63\n"};
        vecs[4] = '{6'd63, 1'b0, 0, "S:63\n"};
        vecs[5] = '{6'd0,  1'b0, 1, "S:00\n"};
        vecs[6] = '{6'd9,  1'b0, 1, "S:09\n"};
        vecs[7] = '{6'd10, 1'b1, 1, "S:10\n"};
        vecs[8] = '{6'd60, 1'b0, 1, "S:60\n"};

        #1 reset = 1'b1;
        #1 check("reset_outputs", {61'd0, tx, busy, frame_done}, 64'b100);
        step(3);
        reset = 1'b0;

        step(1000);
        check("idle_no_frames", 64'(rx_frames.size()), 64'd0);
        check("idle_outputs_1000", {61'd0, tx, busy, frame_done}, 64'b100);

        foreach (vecs[i]) begin
            n0       = rx_frames.size();
            score_in = vecs[i].score;
            send_req = vecs[i].req;
            step(1);
            send_req = 1'b0;
            step(260);
            check($sformatf("vec%0d_count", i), 64'(rx_frames.size() - n0), 64'(vecs[i].n_frames));
            check($sformatf("vec%0d_text", i), 64'(rx_frames[$]), 64'(vecs[i].last_txt));
        end

        // score changes while busy are coalesced to the final value
        n0 = rx_frames.size();
        score_in = 6'd1;
        step(20);
        score_in = 6'd2;
        step(20);
        score_in = 6'd3;
        step(500);
        check("coalesce_count", 64'(rx_frames.size() - n0), 64'd2);
        if (rx_frames.size() >= n0 + 2) begin
            check("coalesce_first", 64'(rx_frames[n0]), 64'(40'("S:01\n")));
            check("coalesce_second", 64'(rx_frames[n0+1]), 64'(40'("S:03\n")));
        end

        // resend while idle, then again mid-frame
        score_in = 6'd12;
        step(500);
        n0 = rx_frames.size();
        send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        step(30);
        send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        step(700);
        check("resend_count", 64'(rx_frames.size() - n0), 64'd2);
        if (rx_frames.size() >= n0 + 2) begin
            check("resend_text_a", 64'(rx_frames[n0]), 64'(40'("S:12\n")));
            check("resend_text_b", 64'(rx_frames[n0+1]), 64'(40'("S:12\n")));
            check("resend_spacing", 64'(rx_starts[n0+1] - rx_starts[n0]), 64'(FRAME_CYC + 2));
        end

        // reset during bit 3 of byte 2, release with score 0: nothing sent
        n0 = rx_frames.size();
        score_in = 6'd20;
        wait_tx_low("reset_a_frame_started");
        step(24 * CPB + 1);
        #2 reset = 1'b1;
        #1 check("reset_a_async", {62'd0, tx, busy}, 64'b10);
        score_in = 6'd0;
        step(3);
        reset = 1'b0;
        step(500);
        check("reset_a_no_frame", 64'(rx_frames.size() - n0), 64'd0);

        // same abort, release with score 45: one fresh full frame
        score_in = 6'd20;
        wait_tx_low("reset_b_frame_started");
        step(24 * CPB + 1);
        #2 reset = 1'b1;
        #1 check("reset_b_async", {62'd0, tx, busy}, 64'b10);
        score_in = 6'd45;
        step(3);
        reset = 1'b0;
        step(500);
        check("reset_b_count", 64'(rx_frames.size() - n0), 64'd1);
        check("reset_b_text", 64'(rx_frames[$]), 64'(40'("S:45\n")));

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) score_in = 6'($urandom_range(0, 63));
            send_req = ($urandom_range(0, 149) == 0);
            step(1);
        end
        send_req = 1'b0;
        step(700);
        check("model_queue_drained", 64'(exp_frames.size()), 64'd0);
        check("final_value_reported", 64'(rx_frames[$]), 64'(fmt(int'(score_in))));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
